// File: rtl/serial_io_pkg.sv
// Shared types and constants for the FF21_xxxx serial IO decode logic.
// The state encoding is shared so that debug taps and checkers see the same values.
package serial_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCESS  = 3'd1,
    ST_ACK     = 3'd2,
    ST_ERROR   = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  localparam logic [15:0] DEFAULT_BASE_ADDR   = 16'h0220;
  localparam int          DEFAULT_STRIDE_LOG2 = 5;

  // A single channel still needs a one-bit index so that port widths never collapse to zero.
  function automatic int ch_idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_io_channel_decoder_if.sv
// Bus-side signal bundle between the bridge IO decode (master) and the UART
// channel decoder (slave).
interface serial_io_channel_decoder_if
  import serial_io_pkg::*;
#(
  parameter int NUM_CHANNELS = 4
);
  localparam int CH_W = ch_idx_width(NUM_CHANNELS);

  // Handshake: the master raises Cycle_H (with IOSelect_H) and keeps Address,
  // ByteSelect_L and Channel_Mask stable until the decoder samples them in IDLE.
  // The decoder answers with exactly one Ack_H pulse per accepted cycle;
  // Decode_Error_H qualifies that pulse as an error. Dropping Cycle_H before Ack_H
  // aborts the cycle with no Ack_H. A new cycle is accepted only after the
  // decoder has seen Cycle_H low.
  logic [15:0]             Address;
  logic                    IOSelect_H;
  logic                    ByteSelect_L;
  logic                    Cycle_H;
  logic [NUM_CHANNELS-1:0] Channel_Mask;
  logic [NUM_CHANNELS-1:0] Port_Enable;
  logic                    Ack_H;
  logic                    Decode_Error_H;
  logic [CH_W-1:0]         Active_Channel;
  logic                    Busy_H;

  modport master (
    output Address, IOSelect_H, ByteSelect_L, Cycle_H, Channel_Mask,
    input  Port_Enable, Ack_H, Decode_Error_H, Active_Channel, Busy_H
  );

  modport slave (
    input  Address, IOSelect_H, ByteSelect_L, Cycle_H, Channel_Mask,
    output Port_Enable, Ack_H, Decode_Error_H, Active_Channel, Busy_H
  );

endinterface

// File: rtl/serial_io_addr_match.sv
// Combinational decode of a 16-bit IO address into a region of equally spaced
// 16-byte register windows: region hit, channel index and valid-hit qualification.
module serial_io_addr_match
  import serial_io_pkg::*;
#(
  parameter int          NUM_CHANNELS = 4,
  parameter logic [15:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int          STRIDE_LOG2  = DEFAULT_STRIDE_LOG2
) (
  input  logic [15:0]                           address,
  input  logic                                  byte_select_l,
  input  logic [NUM_CHANNELS-1:0]               channel_mask,
  output logic                                  in_region,
  output logic                                  valid_hit,
  output logic [ch_idx_width(NUM_CHANNELS)-1:0] ch
);
  localparam int          CH_W        = ch_idx_width(NUM_CHANNELS);
  localparam logic [16:0] REGION_SIZE = 17'(NUM_CHANNELS) << STRIDE_LOG2;
  // Offset bits between the 16-byte register file and the next window must be zero.
  localparam logic [15:0] GAP_MASK    = 16'((32'd1 << STRIDE_LOG2) - 32'd1) & ~16'h000F;

  logic [15:0] offset;
  logic [15:0] ch_full;
  logic        window_ok;
  logic        present;

  always_comb begin
    offset    = address - BASE_ADDR;
    in_region = (address >= BASE_ADDR) && ({1'b0, offset} < REGION_SIZE);
    ch_full   = offset >> STRIDE_LOG2;
    ch        = ch_full[CH_W-1:0];
    window_ok = (offset & GAP_MASK) == 16'h0000;
    present   = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (ch_full == 16'(i)) present = channel_mask[i];
    end
    valid_hit = in_region && window_ok && !byte_select_l && present;
  end

endmodule

// File: rtl/serial_io_channel_decoder.sv
// Registered chip-select generator and bus-cycle sequencer for the bank of 16550
// UART channels: decode, wait-state hold, one-cycle acknowledge and recovery.
module serial_io_channel_decoder
  import serial_io_pkg::*;
#(
  parameter int          NUM_CHANNELS    = 4,
  parameter logic [15:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int          STRIDE_LOG2     = DEFAULT_STRIDE_LOG2,
  parameter int          WAIT_CYCLES     = 4,
  parameter int          RECOVERY_CYCLES = 2
) (
  input  logic                             Clock,
  input  logic                             Reset_H,
  serial_io_channel_decoder_if.slave       bus,
  output state_t                           state_dbg
);
  localparam int CH_W    = ch_idx_width(NUM_CHANNELS);
  localparam int CNT_MAX = (WAIT_CYCLES > RECOVERY_CYCLES) ? WAIT_CYCLES : RECOVERY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD    = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVERY_CYCLES - 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [CH_W-1:0]         chan, chan_nxt;
  logic                    in_region;
  logic                    valid_hit;
  logic [CH_W-1:0]         hit_ch;
  logic                    request;

  logic [NUM_CHANNELS-1:0] port_en_q;
  logic                    ack_q;
  logic                    err_q;
  logic                    busy_q;

  serial_io_addr_match #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .BASE_ADDR    (BASE_ADDR),
    .STRIDE_LOG2  (STRIDE_LOG2)
  ) u_addr_match (
    .address       (bus.Address),
    .byte_select_l (bus.ByteSelect_L),
    .channel_mask  (bus.Channel_Mask),
    .in_region     (in_region),
    .valid_hit     (valid_hit),
    .ch            (hit_ch)
  );

  assign request = bus.IOSelect_H & bus.Cycle_H;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    chan_nxt  = chan;
    case (state)
      ST_IDLE: begin
        // Out-of-region requests belong to other IO devices and are left alone.
        if (request && in_region) begin
          if (valid_hit) begin
            state_nxt = ST_ACCESS;
            cnt_nxt   = WAIT_LOAD;
            chan_nxt  = hit_ch;
          end else begin
            state_nxt = ST_ERROR;
          end
        end
      end
      ST_ACCESS: begin
        if (!bus.Cycle_H) begin
          state_nxt = ST_RECOVER;
          cnt_nxt   = RECOVER_LOAD;
        end else if (cnt == '0) begin
          state_nxt = ST_ACK;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_ACK, ST_ERROR: begin
        state_nxt = ST_RECOVER;
        cnt_nxt   = RECOVER_LOAD;
      end
      ST_RECOVER: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (!bus.Cycle_H) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the current state and registered, so they trail the state by one edge.
  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      chan      <= '0;
      port_en_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      chan      <= chan_nxt;
      port_en_q <= (state == ST_ACCESS || state == ST_ACK) ? (NUM_CHANNELS'(1) << chan) : '0;
      ack_q     <= (state == ST_ACK) || (state == ST_ERROR);
      err_q     <= (state == ST_ERROR);
      busy_q    <= (state != ST_IDLE);
    end
  end

  assign bus.Port_Enable    = port_en_q;
  assign bus.Ack_H          = ack_q;
  assign bus.Decode_Error_H = err_q;
  assign bus.Active_Channel = chan;
  assign bus.Busy_H         = busy_q;
  assign state_dbg          = state;

endmodule

// File: tb/tb_serial_io_channel_decoder.sv
// Bench for serial_io_channel_decoder: timeline model of each bus cycle, per-cycle
// compare against the DUT, pinned literal expectations and an address-decode sweep.
module tb_serial_io_channel_decoder;
  import serial_io_pkg::*;

  localparam int N      = 4;
  localparam int BASE   = 'h0220;
  localparam int SL2    = 5;
  localparam int STRIDE = 1 << SL2;
  localparam int W      = 4;
  localparam int R      = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_io_channel_decoder_if #(.NUM_CHANNELS(N)) bus ();
  state_t state_dbg;

  serial_io_channel_decoder #(
    .NUM_CHANNELS    (N),
    .BASE_ADDR       (16'h0220),
    .STRIDE_LOG2     (SL2),
    .WAIT_CYCLES     (W),
    .RECOVERY_CYCLES (R)
  ) dut (
    .Clock     (clk),
    .Reset_H   (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- decode sweep instances ----------------
  logic [15:0] sw_addr;
  logic        sw1_in, sw1_hit, sw8_in, sw8_hit, sw16_in, sw16_hit;
  logic [0:0]  sw1_ch;
  logic [2:0]  sw8_ch;
  logic [3:0]  sw16_ch;

  serial_io_addr_match #(.NUM_CHANNELS(1), .BASE_ADDR(16'h0220), .STRIDE_LOG2(4)) u_sw1 (
    .address(sw_addr), .byte_select_l(1'b0), .channel_mask(1'b1),
    .in_region(sw1_in), .valid_hit(sw1_hit), .ch(sw1_ch));
  serial_io_addr_match #(.NUM_CHANNELS(8), .BASE_ADDR(16'h0400), .STRIDE_LOG2(6)) u_sw8 (
    .address(sw_addr), .byte_select_l(1'b0), .channel_mask(8'hFF),
    .in_region(sw8_in), .valid_hit(sw8_hit), .ch(sw8_ch));
  serial_io_addr_match #(.NUM_CHANNELS(16), .BASE_ADDR(16'h0220), .STRIDE_LOG2(4)) u_sw16 (
    .address(sw_addr), .byte_select_l(1'b0), .channel_mask(16'hFFFF),
    .in_region(sw16_in), .valid_hit(sw16_hit), .ch(sw16_ch));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];   // {port_enable[3:0], ack, err, active[1:0], busy}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted cycle is described by the edge it was sampled on (t_req), the edge
  // Cycle_H was seen low during the wait states (abort_e) and the edge the decoder
  // returns to idle (done_e). Outputs after edge n follow from those numbers.
  int       edge_n = 0;
  int       t_req  = -1;
  int       abort_e, done_e, mch;
  bit       hit;
  logic [1:0] m_act = 2'b00;

  always @(posedge clk) begin
    logic [3:0] e_pe;
    logic       e_ack, e_err, e_busy;
    int         off, rec, en_end;
    edge_n++;
    e_pe = 4'b0; e_ack = 1'b0; e_err = 1'b0; e_busy = 1'b0;
    if (rst) begin
      t_req = -1;
      m_act = 2'b00;
    end else begin
      if (t_req < 0 || (done_e >= 0 && edge_n > done_e)) begin
        off = int'(bus.Address) - BASE;
        if (bus.IOSelect_H && bus.Cycle_H && off >= 0 && off < N * STRIDE) begin
          mch     = off / STRIDE;
          hit     = (off % STRIDE) < 16 && !bus.ByteSelect_L && bus.Channel_Mask[mch];
          t_req   = edge_n;
          abort_e = -1;
          done_e  = -1;
          if (hit) m_act = mch[1:0];
        end
      end else begin
        if (hit && abort_e < 0 && edge_n >= t_req + 1 && edge_n <= t_req + W && !bus.Cycle_H)
          abort_e = edge_n;
        rec = !hit ? t_req + 1 : (abort_e >= 0 ? abort_e : t_req + W + 1);
        if (done_e < 0 && edge_n >= rec + R && !bus.Cycle_H) done_e = edge_n;
      end
      if (t_req >= 0) begin
        en_end = (abort_e >= 0) ? abort_e : t_req + W + 1;
        e_busy = edge_n >= t_req + 1 && (done_e < 0 || edge_n <= done_e);
        if (hit && edge_n >= t_req + 1 && edge_n <= en_end) e_pe = 4'b0001 << mch;
        e_ack = (hit && abort_e < 0 && edge_n == t_req + W + 1) || (!hit && edge_n == t_req + 1);
        e_err = !hit && edge_n == t_req + 1;
      end
    end
    exp_q.push_back({e_pe, e_ack, e_err, m_act, e_busy});
  end

  always @(negedge clk) begin
    logic [8:0] ev;
    if (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      check("port_enable",    32'(bus.Port_Enable),    32'(ev[8:5]));
      check("ack",            32'(bus.Ack_H),          32'(ev[4]));
      check("decode_error",   32'(bus.Decode_Error_H), 32'(ev[3]));
      check("active_channel", 32'(bus.Active_Channel), 32'(ev[2:1]));
      check("busy",           32'(bus.Busy_H),         32'(ev[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] a, input logic bsel, input logic [3:0] mask);
    bus.Address      = a;
    bus.ByteSelect_L = bsel;
    bus.Channel_Mask = mask;
    bus.IOSelect_H   = 1'b1;
    bus.Cycle_H      = 1'b1;
  endtask

  task automatic release_bus();
    bus.IOSelect_H = 1'b0;
    bus.Cycle_H    = 1'b0;
  endtask

  task automatic sweep_get(input int cfg, output logic inr, output logic hv, output int ch);
    case (cfg)
      0:       begin inr = sw1_in;  hv = sw1_hit;  ch = int'(sw1_ch);  end
      1:       begin inr = sw8_in;  hv = sw8_hit;  ch = int'(sw8_ch);  end
      default: begin inr = sw16_in; hv = sw16_hit; ch = int'(sw16_ch); end
    endcase
  endtask

  task automatic sweep_cfg(input int cfg, input int n, input int base, input int sl2);
    logic inr, hv;
    int   ch;
    for (int k = 0; k < n; k++) begin
      for (int top = 0; top < 2; top++) begin
        sw_addr = 16'(base + (k << sl2) + (top != 0 ? 15 : 0));
        #1;
        sweep_get(cfg, inr, hv, ch);
        check("sweep_hit", 32'(hv), 32'd1);
        check("sweep_onehot", 32'(1) << ch, 32'(1) << k);
      end
    end
    if (sl2 > 4) begin
      sw_addr = 16'(base + 16);
      #1;
      sweep_get(cfg, inr, hv, ch);
      check("sweep_gap_in_region", 32'(inr), 32'd1);
      check("sweep_gap_no_hit", 32'(hv), 32'd0);
    end
    sw_addr = 16'(base + (n << sl2));
    #1;
    sweep_get(cfg, inr, hv, ch);
    check("sweep_past_end", 32'(inr), 32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    sw_addr = 16'h0000;
    bus.Address = 16'h0000; bus.ByteSelect_L = 1'b0; bus.Channel_Mask = 4'hF;
    release_bus();
    tick(3);
    check("reset_port_enable", 32'(bus.Port_Enable), 32'h0);
    check("reset_busy", 32'(bus.Busy_H), 32'h0);
    check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;
    tick(2);

    // Channel 1 access with Cycle_H held through the acknowledge
    drive(16'h0240, 1'b0, 4'hF);
    tick(2);
    check("t1_pe_edge1", 32'(bus.Port_Enable), 32'h2);
    check("t1_active", 32'(bus.Active_Channel), 32'h1);
    tick(4);
    check("t1_ack_edge5", 32'(bus.Ack_H), 32'h1);
    check("t1_pe_edge5", 32'(bus.Port_Enable), 32'h2);
    tick(1);
    check("t1_pe_edge6", 32'(bus.Port_Enable), 32'h0);
    tick(1);
    release_bus();
    tick(1);
    check("t1_busy_edge8", 32'(bus.Busy_H), 32'h1);
    tick(1);
    check("t1_busy_edge9", 32'(bus.Busy_H), 32'h0);
    tick(2);

    // Odd byte inside a window is an error termination
    drive(16'h0221, 1'b1, 4'hF);
    tick(2);
    check("t2_ack", 32'(bus.Ack_H), 32'h1);
    check("t2_err", 32'(bus.Decode_Error_H), 32'h1);
    check("t2_pe", 32'(bus.Port_Enable), 32'h0);
    release_bus();
    tick(5);

    // Gap between windows is an error; addresses outside the region are ignored
    drive(16'h0230, 1'b0, 4'hF);
    tick(2);
    check("t3_gap_err", 32'(bus.Decode_Error_H), 32'h1);
    release_bus();
    tick(5);
    drive(16'h0300, 1'b0, 4'hF);
    tick(3);
    check("t3_above_busy", 32'(bus.Busy_H), 32'h0);
    drive(16'h0100, 1'b0, 4'hF);
    tick(3);
    check("t3_below_ack", 32'(bus.Ack_H), 32'h0);
    drive(16'h021F, 1'b0, 4'hF);
    tick(3);
    drive(16'h02A0, 1'b0, 4'hF);
    tick(3);
    release_bus();
    tick(2);

    // Masked channel errors; mask/address changes after the sample are ignored
    drive(16'h0240, 1'b0, 4'b1101);
    tick(2);
    check("t4_masked_err", 32'(bus.Decode_Error_H), 32'h1);
    release_bus();
    tick(5);
    drive(16'h0220, 1'b0, 4'hF);
    tick(2);
    bus.Channel_Mask = 4'h0;
    bus.Address = 16'h0300;
    tick(4);
    check("t4_late_mask_ack", 32'(bus.Ack_H), 32'h1);
    check("t4_late_mask_pe", 32'(bus.Port_Enable), 32'h1);
    release_bus();
    bus.Channel_Mask = 4'hF;
    tick(6);

    // Abort: Cycle_H seen low at edge 2
    drive(16'h0260, 1'b0, 4'hF);
    tick(2);
    release_bus();
    tick(1);
    check("t5_pe_edge2", 32'(bus.Port_Enable), 32'h4);
    tick(1);
    check("t5_pe_edge3", 32'(bus.Port_Enable), 32'h0);
    tick(6);

    // Reset in the middle of an access
    drive(16'h0280, 1'b0, 4'hF);
    tick(3);
    rst = 1'b1;
    tick(1);
    check("t6_rst_pe", 32'(bus.Port_Enable), 32'h0);
    check("t6_rst_active", 32'(bus.Active_Channel), 32'h0);
    check("t6_rst_busy", 32'(bus.Busy_H), 32'h0);
    rst = 1'b0;
    release_bus();
    tick(3);

    // Cycle_H held through RECOVER stalls, then a back-to-back access
    drive(16'h022F, 1'b0, 4'hF);
    tick(13);
    check("t7_stall_busy", 32'(bus.Busy_H), 32'h1);
    check("t7_stall_state", 32'(state_dbg), 32'(ST_RECOVER));
    release_bus();
    tick(1);
    drive(16'h026F, 1'b0, 4'hF);
    tick(2);
    check("t7_b2b_pe", 32'(bus.Port_Enable), 32'h4);
    tick(6);
    release_bus();
    tick(6);

    // Top byte of every window
    for (int k = 0; k < N; k++) begin
      drive(16'(BASE + k * STRIDE + 15), 1'b0, 4'hF);
      tick(7);
      release_bus();
      tick(4);
    end

    sweep_cfg(0, 1, 'h0220, 4);
    sweep_cfg(1, 8, 'h0400, 6);
    sweep_cfg(2, 16, 'h0220, 4);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
